// File: rtl/aib_avmm_req_dispatch.sv
// Request fan-out for the AIB configuration Avalon-MM bus: one master transaction at a time, one-hot strobe
// to the decoded channel, response returned to the master. Optional abort counter: AIB_AVMM_DISPATCH_TIMEOUT_EN.
module aib_avmm_req_dispatch #(
  parameter int NBR_CHNLS     = 24,
  parameter int ADDR_W        = 17,
  parameter int CHAN_ADDR_LSB = 11,
  parameter int TIMEOUT_CYC   = 255
) (
  input  logic                      i_cfg_avmm_clk,
  input  logic                      i_cfg_avmm_rst,
  input  logic [ADDR_W-1:0]         i_cfg_avmm_addr,
  input  logic                      i_cfg_avmm_read,
  input  logic                      i_cfg_avmm_write,
  input  logic [31:0]               i_cfg_avmm_wdata,
  input  logic [3:0]                i_cfg_avmm_byte_en,
  output logic                      o_cfg_avmm_waitreq,
  output logic                      o_cfg_avmm_rdatavld,
  output logic [31:0]               o_cfg_avmm_rdata,
  output logic [NBR_CHNLS-1:0]      o_chnl_read,
  output logic [NBR_CHNLS-1:0]      o_chnl_write,
  output logic [CHAN_ADDR_LSB-1:0]  o_chnl_addr,
  output logic [31:0]               o_chnl_wdata,
  output logic [3:0]                o_chnl_byte_en,
  input  logic [NBR_CHNLS-1:0]      i_chnl_waitreq,
  input  logic [NBR_CHNLS-1:0]      i_chnl_rdatavld,
  input  logic [32*NBR_CHNLS-1:0]   i_chnl_rdata,
  output logic                      o_err
);

  localparam int IDX_W = ADDR_W - CHAN_ADDR_LSB;
  localparam int SEL_W = (NBR_CHNLS > 1) ? $clog2(NBR_CHNLS) : 1;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_RDWAIT, S_DONE} state_t;

  state_t                    state_q, state_d;
  logic [SEL_W-1:0]          sel_q, sel_d;
  logic                      cmd_rd_q, cmd_rd_d;
  logic [CHAN_ADDR_LSB-1:0]  addr_q, addr_d;
  logic [31:0]               wdata_q, wdata_d;
  logic [3:0]                be_q, be_d;
  logic [NBR_CHNLS-1:0]      rd_strb_q, rd_strb_d;
  logic [NBR_CHNLS-1:0]      wr_strb_q, wr_strb_d;
  logic                      waitreq_q, waitreq_d;
  logic                      rdatavld_q, rdatavld_d;
  logic [31:0]               rdata_q, rdata_d;
  logic                      err_q, err_d;

  logic [IDX_W-1:0]          req_idx;
  logic                      req_any;
  logic                      req_bad;
  logic [NBR_CHNLS-1:0]      req_onehot;
  logic                      sel_waitreq;
  logic                      sel_rdatavld;
  logic [31:0]               sel_rdata;

  assign req_idx = i_cfg_avmm_addr[ADDR_W-1:CHAN_ADDR_LSB];
  assign req_any = i_cfg_avmm_read | i_cfg_avmm_write;
  assign req_bad = (req_idx >= IDX_W'(NBR_CHNLS)) | (i_cfg_avmm_read & i_cfg_avmm_write);

  // Only the captured channel's handshake is ever looked at; all other lanes are don't-care.
  always_comb begin
    req_onehot   = '0;
    sel_waitreq  = 1'b1;
    sel_rdatavld = 1'b0;
    sel_rdata    = '0;
    for (int i = 0; i < NBR_CHNLS; i++) begin
      req_onehot[i] = (req_idx == IDX_W'(i));
      if (sel_q == SEL_W'(i)) begin
        sel_waitreq  = i_chnl_waitreq[i];
        sel_rdatavld = i_chnl_rdatavld[i];
        sel_rdata    = i_chnl_rdata[32*i +: 32];
      end
    end
  end

`ifdef AIB_AVMM_DISPATCH_TIMEOUT_EN
  localparam int          CNT_W         = ($clog2(TIMEOUT_CYC + 1) > 8) ? $clog2(TIMEOUT_CYC + 1) : 8;
  localparam logic [31:0] TIMEOUT_RDATA = 32'hBAD0_0BAD;

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             tmo_hit;

  assign tmo_hit = (cnt_q == CNT_W'(TIMEOUT_CYC - 1));
`else
  logic unused_timeout_cyc;
  assign unused_timeout_cyc = ^TIMEOUT_CYC;
`endif

  always_comb begin
    // NOTE: every variable gets a default before the case, so no path can infer a latch.
    state_d    = state_q;
    sel_d      = sel_q;
    cmd_rd_d   = cmd_rd_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    be_d       = be_q;
    rd_strb_d  = rd_strb_q;
    wr_strb_d  = wr_strb_q;
    waitreq_d  = 1'b1;
    rdatavld_d = 1'b0;
    rdata_d    = '0;
    err_d      = 1'b0;
`ifdef AIB_AVMM_DISPATCH_TIMEOUT_EN
    cnt_d      = cnt_q;
`endif

    case (state_q)
      S_IDLE: begin
        if (req_any) begin
          sel_d    = req_idx[SEL_W-1:0];
          cmd_rd_d = i_cfg_avmm_read;
          addr_d   = i_cfg_avmm_addr[CHAN_ADDR_LSB-1:0];
          wdata_d  = i_cfg_avmm_wdata;
          be_d     = i_cfg_avmm_byte_en;
          if (req_bad) begin
            state_d    = S_DONE;
            waitreq_d  = 1'b0;
            err_d      = 1'b1;
            rdatavld_d = i_cfg_avmm_read;
          end else begin
            state_d   = S_ISSUE;
            rd_strb_d = i_cfg_avmm_read ? req_onehot : '0;
            wr_strb_d = i_cfg_avmm_read ? '0 : req_onehot;
`ifdef AIB_AVMM_DISPATCH_TIMEOUT_EN
            cnt_d     = '0;
`endif
          end
        end
      end

      S_ISSUE: begin
`ifdef AIB_AVMM_DISPATCH_TIMEOUT_EN
        cnt_d = cnt_q + 1'b1;
`endif
        if (!sel_waitreq) begin
          rd_strb_d = '0;
          wr_strb_d = '0;
          if (!cmd_rd_q) begin
            state_d   = S_DONE;
            waitreq_d = 1'b0;
          end else if (sel_rdatavld) begin
            state_d    = S_DONE;
            waitreq_d  = 1'b0;
            rdatavld_d = 1'b1;
            rdata_d    = sel_rdata;
          end else begin
            state_d = S_RDWAIT;
          end
        end
`ifdef AIB_AVMM_DISPATCH_TIMEOUT_EN
        else if (tmo_hit) begin
          rd_strb_d  = '0;
          wr_strb_d  = '0;
          state_d    = S_DONE;
          waitreq_d  = 1'b0;
          err_d      = 1'b1;
          rdatavld_d = cmd_rd_q;
          rdata_d    = cmd_rd_q ? TIMEOUT_RDATA : '0;
        end
`endif
      end

      S_RDWAIT: begin
`ifdef AIB_AVMM_DISPATCH_TIMEOUT_EN
        cnt_d = cnt_q + 1'b1;
`endif
        if (sel_rdatavld) begin
          state_d    = S_DONE;
          waitreq_d  = 1'b0;
          rdatavld_d = 1'b1;
          rdata_d    = sel_rdata;
        end
`ifdef AIB_AVMM_DISPATCH_TIMEOUT_EN
        else if (tmo_hit) begin
          state_d    = S_DONE;
          waitreq_d  = 1'b0;
          err_d      = 1'b1;
          rdatavld_d = 1'b1;
          rdata_d    = TIMEOUT_RDATA;
        end
`endif
      end

      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge i_cfg_avmm_clk) begin
    // NOTE: non-blocking assignments keep every register sampling the pre-edge values.
    if (i_cfg_avmm_rst) begin
      state_q    <= S_IDLE;
      sel_q      <= '0;
      cmd_rd_q   <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      be_q       <= '0;
      rd_strb_q  <= '0;
      wr_strb_q  <= '0;
      waitreq_q  <= 1'b1;
      rdatavld_q <= 1'b0;
      rdata_q    <= '0;
      err_q      <= 1'b0;
`ifdef AIB_AVMM_DISPATCH_TIMEOUT_EN
      cnt_q      <= '0;
`endif
    end else begin
      state_q    <= state_d;
      sel_q      <= sel_d;
      cmd_rd_q   <= cmd_rd_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      be_q       <= be_d;
      rd_strb_q  <= rd_strb_d;
      wr_strb_q  <= wr_strb_d;
      waitreq_q  <= waitreq_d;
      rdatavld_q <= rdatavld_d;
      rdata_q    <= rdata_d;
      err_q      <= err_d;
`ifdef AIB_AVMM_DISPATCH_TIMEOUT_EN
      cnt_q      <= cnt_d;
`endif
    end
  end

  assign o_cfg_avmm_waitreq  = waitreq_q;
  assign o_cfg_avmm_rdatavld = rdatavld_q;
  assign o_cfg_avmm_rdata    = rdata_q;
  assign o_chnl_read         = rd_strb_q;
  assign o_chnl_write        = wr_strb_q;
  assign o_chnl_addr         = addr_q;
  assign o_chnl_wdata        = wdata_q;
  assign o_chnl_byte_en      = be_q;
  assign o_err               = err_q;

endmodule

// File: tb/tb_aib_avmm_req_dispatch.sv
// Bench for aib_avmm_req_dispatch: per-transaction expected cycle tables checked every cycle, plus literal pins.
module tb_aib_avmm_req_dispatch;

  localparam int NCH = 24;
  localparam int AW  = 17;
  localparam int LSB = 11;
  localparam int TO  = 8;

  logic                 clk = 1'b0;
  logic                 rst;
  logic [AW-1:0]        addr;
  logic                 read, write;
  logic [31:0]          wdata;
  logic [3:0]           be;
  logic                 m_waitreq, m_rdatavld;
  logic [31:0]          m_rdata;
  logic [NCH-1:0]       c_read, c_write;
  logic [LSB-1:0]       c_addr;
  logic [31:0]          c_wdata;
  logic [3:0]           c_be;
  logic [NCH-1:0]       c_waitreq, c_rdatavld;
  logic [32*NCH-1:0]    c_rdata;
  logic                 err;

  always #5 clk = ~clk;

  aib_avmm_req_dispatch #(
    .NBR_CHNLS(NCH), .ADDR_W(AW), .CHAN_ADDR_LSB(LSB), .TIMEOUT_CYC(TO)
  ) dut (
    .i_cfg_avmm_clk(clk), .i_cfg_avmm_rst(rst),
    .i_cfg_avmm_addr(addr), .i_cfg_avmm_read(read), .i_cfg_avmm_write(write),
    .i_cfg_avmm_wdata(wdata), .i_cfg_avmm_byte_en(be),
    .o_cfg_avmm_waitreq(m_waitreq), .o_cfg_avmm_rdatavld(m_rdatavld), .o_cfg_avmm_rdata(m_rdata),
    .o_chnl_read(c_read), .o_chnl_write(c_write), .o_chnl_addr(c_addr),
    .o_chnl_wdata(c_wdata), .o_chnl_byte_en(c_be),
    .i_chnl_waitreq(c_waitreq), .i_chnl_rdatavld(c_rdatavld), .i_chnl_rdata(c_rdata),
    .o_err(err)
  );

  typedef struct packed {
    logic           waitreq;
    logic           rdatavld;
    logic [31:0]    rdata;
    logic [NCH-1:0] rd_strb;
    logic [NCH-1:0] wr_strb;
    logic           err;
    logic           pay;
    logic [LSB-1:0] addr;
    logic [31:0]    wdata;
    logic [3:0]     be;
  } exp_t;

  exp_t exp_arr[int];
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_fail = 0;
  int   txn_id = 0;
  int   txn_base = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  function automatic exp_t idle_exp();
    exp_t e;
    e = '0;
    e.waitreq = 1'b1;
    return e;
  endfunction

  // Observations of the most recent transaction, used for the literal pins.
  int             seen_id = -1;
  int             obs_strb, obs_done;
  logic           obs_rdv, obs_err;
  logic [31:0]    obs_rdata;
  logic [NCH-1:0] obs_rd_or, obs_wr_or;
  logic [LSB-1:0] obs_addr;

  always @(negedge clk) begin
    exp_t e;
    if (exp_arr.exists(cyc)) begin
      e = exp_arr[cyc];
      check($sformatf("c%0d waitreq", cyc), 64'(m_waitreq), 64'(e.waitreq));
      check($sformatf("c%0d rdatavld", cyc), 64'(m_rdatavld), 64'(e.rdatavld));
      check($sformatf("c%0d rdata", cyc), 64'(m_rdata), 64'(e.rdata));
      check($sformatf("c%0d chnl_read", cyc), 64'(c_read), 64'(e.rd_strb));
      check($sformatf("c%0d chnl_write", cyc), 64'(c_write), 64'(e.wr_strb));
      check($sformatf("c%0d err", cyc), 64'(err), 64'(e.err));
      if (e.pay) begin
        check($sformatf("c%0d chnl_addr", cyc), 64'(c_addr), 64'(e.addr));
        check($sformatf("c%0d chnl_wdata", cyc), 64'(c_wdata), 64'(e.wdata));
        check($sformatf("c%0d chnl_be", cyc), 64'(c_be), 64'(e.be));
      end
    end
    if (txn_id != seen_id) begin
      seen_id   = txn_id;
      obs_strb  = 0;
      obs_done  = -1;
      obs_rdv   = 1'b0;
      obs_err   = 1'b0;
      obs_rdata = '0;
      obs_rd_or = '0;
      obs_wr_or = '0;
      obs_addr  = '0;
    end
    if ((c_read | c_write) != '0) begin
      obs_strb++;
      obs_addr = c_addr;
    end
    obs_rd_or = obs_rd_or | c_read;
    obs_wr_or = obs_wr_or | c_write;
    if (!m_waitreq && obs_done < 0) begin
      obs_done  = cyc - txn_base;
      obs_rdv   = m_rdatavld;
      obs_rdata = m_rdata;
      obs_err   = err;
    end
  end

  task automatic chnl_idle();
    c_waitreq  = '0;
    c_rdatavld = '0;
    for (int i = 0; i < NCH; i++) c_rdata[32*i +: 32] = 32'h6666_6666;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) begin
      exp_arr[cyc] = idle_exp();
      @(posedge clk); #1;
    end
  endtask

  // One master transaction. Cycle 0 is the request cycle; the selected channel holds waitreq for wait_c
  // cycles after the strobe appears, and read data arrives rv_dly cycles after the accept cycle.
  task automatic run_txn(input bit rd, input bit wr, input logic [AW-1:0] a, input logic [31:0] wd,
                         input logic [3:0] b, input int wait_c, input int rv_dly,
                         input logic [NCH-1:0] stray, input logic [31:0] rdat);
    int             idx, acc, comp, done, strb_end;
    bit             dec_err, tmo;
    logic [31:0]    exp_rd;
    logic [NCH-1:0] sel_vec;
    exp_t           e;
    idx      = int'(a[AW-1:LSB]);
    dec_err  = (idx >= NCH) || (rd && wr);
    acc      = 1 + wait_c;
    comp     = rd ? acc + rv_dly : acc;
    tmo      = 1'b0;
    sel_vec  = '0;
    strb_end = 0;
    if (dec_err) begin
      done = 1;
    end else begin
      sel_vec[idx] = 1'b1;
      done = comp + 1;
`ifdef AIB_AVMM_DISPATCH_TIMEOUT_EN
      if (comp > TO) begin
        tmo  = 1'b1;
        done = TO + 1;
      end
`endif
      strb_end = (acc < done) ? acc : done - 1;
    end
    exp_rd   = tmo ? 32'hBAD0_0BAD : (dec_err ? 32'h0 : rdat);
    txn_base = cyc;
    txn_id++;
    for (int c = 0; c <= done; c++) begin
      e = idle_exp();
      e.waitreq  = (c != done);
      e.rdatavld = (c == done) && rd;
      e.rdata    = ((c == done) && rd) ? exp_rd : 32'h0;
      e.err      = (c == done) && (dec_err || tmo);
      if (c >= 1 && c <= strb_end) begin
        e.pay   = 1'b1;
        e.addr  = a[LSB-1:0];
        e.wdata = wd;
        e.be    = b;
        if (rd) e.rd_strb = sel_vec;
        else    e.wr_strb = sel_vec;
      end
      exp_arr[txn_base + c] = e;
    end
    for (int c = 0; c <= done; c++) begin
      read  = rd;
      write = wr;
      addr  = a;
      wdata = wd;
      be    = b;
      chnl_idle();
      c_rdatavld = stray & ~sel_vec;
      if (!dec_err) begin
        c_waitreq[idx] = (c >= 1) && (c < acc);
        c_rdata[32*idx +: 32] = (rd && c == comp) ? rdat : ~rdat;
        if (rd && c == comp) c_rdatavld[idx] = 1'b1;
      end
      @(posedge clk); #1;
    end
    read  = 1'b0;
    write = 1'b0;
    chnl_idle();
  endtask

  initial begin
    exp_t e;
    rst   = 1'b1;
    read  = 1'b0;
    write = 1'b0;
    addr  = '0;
    wdata = '0;
    be    = '0;
    chnl_idle();
    @(posedge clk); @(posedge clk); #1;
    idle(1);                                   // reset values while reset is held
    rst = 1'b0;
    idle(2);

    // Write, zero-wait channel 3
    run_txn(1'b0, 1'b1, 17'h0_1804, 32'hA5A5_1234, 4'hF, 0, 0, '0, 32'h0);
    check("t1 write vector", 64'(obs_wr_or), 64'h00_0008);
    check("t1 strobe cycles", 64'(obs_strb), 64'd1);
    check("t1 chnl addr", 64'(obs_addr), 64'h004);
    check("t1 done cycle", 64'(obs_done), 64'd2);
    check("t1 err", 64'(obs_err), 64'd0);

    // Read channel 23: 4 wait cycles, data 2 cycles after accept
    run_txn(1'b1, 1'b0, 17'h0_B8AB, 32'h0, 4'hF, 4, 2, '0, 32'hDEAD_0017);
    check("t2 read vector", 64'(obs_rd_or), 64'h80_0000);
    check("t2 strobe cycles", 64'(obs_strb), 64'd5);
    check("t2 done cycle", 64'(obs_done), 64'd8);
    check("t2 rdatavld", 64'(obs_rdv), 64'd1);
    check("t2 rdata", 64'(obs_rdata), 64'hDEAD_0017);

    // Decode error: index 30
    run_txn(1'b1, 1'b0, 17'h0_F03C, 32'h0, 4'hF, 0, 0, '0, 32'h0);
    check("t3 strobe cycles", 64'(obs_strb), 64'd0);
    check("t3 done cycle", 64'(obs_done), 64'd1);
    check("t3 rdatavld", 64'(obs_rdv), 64'd1);
    check("t3 rdata", 64'(obs_rdata), 64'd0);
    check("t3 err", 64'(obs_err), 64'd1);

    // Read channel 5 with channel 6 raising stray rdatavld throughout
    run_txn(1'b1, 1'b0, 17'h0_2820, 32'h0, 4'hF, 1, 3, 24'h00_0040, 32'h5555_5555);
    check("t4 rdata", 64'(obs_rdata), 64'h5555_5555);
    idle(1);

    // Read and write together: decode error with rdatavld
    run_txn(1'b1, 1'b1, 17'h0_0900, 32'h1111_2222, 4'hF, 0, 0, '0, 32'h0);
    // Waited write to channel 0, then back-to-back zero-wait write to channel 23
    run_txn(1'b0, 1'b1, 17'h0_0010, 32'hCAFE_0000, 4'h3, 2, 0, '0, 32'h0);
    run_txn(1'b0, 1'b1, 17'h0_B800, 32'h0BAD_F00D, 4'hC, 0, 0, '0, 32'h0);
    // First out-of-range index (24) as a write
    run_txn(1'b0, 1'b1, 17'h0_C7FF, 32'h7777_7777, 4'hF, 0, 0, '0, 32'h0);
    check("t8 rdatavld", 64'(obs_rdv), 64'd0);
    // Read with data in the accept cycle
    run_txn(1'b1, 1'b0, 17'h0_67FF, 32'h0, 4'h1, 0, 0, 24'hFF_EFFF, 32'h1234_ABCD);
    check("t9 done cycle", 64'(obs_done), 64'd2);
    idle(2);

    // Reset during RDWAIT of a channel-2 read; channel data arrives one cycle later
    txn_base = cyc;
    txn_id++;
    exp_arr[cyc] = idle_exp();
    e = idle_exp();
    e.rd_strb = 24'h00_0004;
    e.pay     = 1'b1;
    e.addr    = 11'h010;
    e.wdata   = 32'h0;
    e.be      = 4'hF;
    exp_arr[cyc + 1] = e;
    exp_arr[cyc + 2] = idle_exp();
    exp_arr[cyc + 3] = idle_exp();
    exp_arr[cyc + 4] = idle_exp();
    read = 1'b1; addr = 17'h0_1010; wdata = 32'h0; be = 4'hF;
    @(posedge clk); #1;                        // cycle 1: strobe, channel accepts
    c_waitreq = '0;
    @(posedge clk); #1;                        // cycle 2: RDWAIT, reset asserted
    rst = 1'b1;
    @(posedge clk); #1;                        // cycle 3: reset taken, late channel data
    rst  = 1'b0;
    read = 1'b0;
    c_rdatavld[2] = 1'b1;
    c_rdata[32*2 +: 32] = 32'h2222_2222;
    @(posedge clk); #1;                        // cycle 4: must still be idle
    chnl_idle();
    check("t10 no master rdatavld", 64'(obs_rdv), 64'd0);
    check("t10 no completion", 64'(obs_done), 64'hFFFF_FFFF_FFFF_FFFF);
    run_txn(1'b0, 1'b1, 17'h0_4808, 32'h9999_0009, 4'hF, 1, 0, '0, 32'h0);
    check("t11 write vector", 64'(obs_wr_or), 64'h00_0200);
    check("t11 done cycle", 64'(obs_done), 64'd3);

`ifdef AIB_AVMM_DISPATCH_TIMEOUT_EN
    // Channel 0 never accepts: abort after TO strobe cycles
    run_txn(1'b1, 1'b0, 17'h0_0000, 32'h0, 4'hF, 40, 0, '0, 32'h0);
    check("t12 strobe cycles", 64'(obs_strb), 64'd8);
    check("t12 done cycle", 64'(obs_done), 64'd9);
    check("t12 rdata", 64'(obs_rdata), 64'hBAD0_0BAD);
    check("t12 rdatavld", 64'(obs_rdv), 64'd1);
    check("t12 err", 64'(obs_err), 64'd1);
`endif

    idle(3);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
